// File: rtl/imem_boot_ctrl_if.sv
// Loader stream bundle for imem_boot_ctrl.
// The loader (master) drives start/valid/data/last; the controller (slave) returns ready.
interface imem_boot_ctrl_if #(
    parameter int WORD = 32
) ();
    logic            load_start;
    logic            load_valid;
    logic [WORD-1:0] load_data;
    logic            load_last;
    logic            load_ready;

    modport master (
        output load_start,
        output load_valid,
        output load_data,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_start,
        input  load_valid,
        input  load_data,
        input  load_last,
        output load_ready
    );
endinterface

// File: rtl/imem_boot_ctrl.sv
// imem_boot_ctrl: shares the single-port instruction memory between the program loader
// stream and the core fetch port. Holds the core in reset/stall while a program streams in,
// spends one cycle flushing the memory read pipeline, then releases the core.
// Optional feature macro: IMEM_CHECKSUM_EN (running sum of accepted words on checksum_o).
//
// state | meaning
// IDLE  | no runnable program; core held in reset, loader not accepted
// LOAD  | accepting loader words into memory from address 0
// FLUSH | one cycle: core address drives memory so read data is valid on RUN entry
// RUN   | memory owned by core; core out of reset and not stalled
module imem_boot_ctrl #(
    parameter int WORD  = 32,
    parameter int AW    = 8,
    parameter int DEPTH = 256
) (
    input  logic            clk,
    input  logic            reset,
    imem_boot_ctrl_if.slave load_if,
    input  logic [AW-1:0]   core_addr_i,
    output logic [WORD-1:0] core_inst_o,
    output logic            core_stall_o,
    output logic            core_rst_n_o,
    output logic [AW-1:0]   mem_A_o,
    output logic            mem_W_o,
    output logic [WORD-1:0] mem_D_o,
    input  logic [WORD-1:0] mem_Q_i,
    output logic [AW:0]     load_count_o,
    output logic            done_o,
    output logic            err_o,
    output logic [WORD-1:0] checksum_o
);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
    localparam logic [PW-1:0] DEPTH_M1 = PW'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_FLUSH, S_RUN} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          err_q, err_d;
    logic          done_q, done_d;
    logic          rst_n_q, rst_n_d;
    logic          accept;

    // A word is taken only in LOAD with room left; a start in the same cycle drops it.
    always_comb begin
        accept = (state_q == S_LOAD) && (wr_ptr_q < DEPTH_P)
                 && load_if.load_valid && !load_if.load_start;
    end

    // State and registered status outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
            rst_n_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            err_q    <= err_d;
            done_q   <= done_d;
            rst_n_q  <= rst_n_d;
        end
    end

    // Next state; a load start overrides every other transition.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_IDLE;
            S_LOAD: begin
                if (accept) begin
                    if (load_if.load_last)        state_d = S_FLUSH;
                    else if (wr_ptr_q == DEPTH_M1) state_d = S_IDLE;
                end
            end
            S_FLUSH: state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
        if (load_if.load_start) state_d = S_LOAD;
    end

    // Next values of write pointer and status flags; status follows the state being entered.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        err_d    = err_q;
        if (load_if.load_start) begin
            wr_ptr_d = '0;
            err_d    = 1'b0;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (!load_if.load_last && (wr_ptr_q == DEPTH_M1)) err_d = 1'b1;
        end
        done_d  = (state_d == S_RUN);
        rst_n_d = (state_d == S_RUN);
    end

    // Memory port and handshake decode from current state.
    always_comb begin
        load_if.load_ready = 1'b0;
        core_stall_o       = 1'b1;
        mem_W_o            = 1'b0;
        mem_A_o            = core_addr_i;
        mem_D_o            = load_if.load_data;
        case (state_q)
            S_LOAD: begin
                load_if.load_ready = (wr_ptr_q < DEPTH_P);
                mem_A_o            = wr_ptr_q[AW-1:0];
                mem_W_o            = accept;
            end
            S_RUN:   core_stall_o = 1'b0;
            default: ;
        endcase
    end

    assign core_inst_o  = mem_Q_i;
    assign core_rst_n_o = rst_n_q;
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign load_count_o = wr_ptr_q;

`ifdef IMEM_CHECKSUM_EN
    logic [WORD-1:0] sum_q, sum_d;

    // Running modular sum of accepted words, cleared by start.
    always_comb begin
        sum_d = sum_q;
        if (load_if.load_start) sum_d = '0;
        else if (accept)        sum_d = sum_q + load_if.load_data;
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (!reset) sum_q <= '0;
        else        sum_q <= sum_d;
    end

    assign checksum_o = sum_q;
`else
    assign checksum_o = '0;
`endif
endmodule

// File: tb/tb_imem_boot_ctrl.sv
module tb_imem_boot_ctrl;
    localparam int WORD  = 32;
    localparam int AW    = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    imem_boot_ctrl_if #(.WORD(WORD)) lif ();

    logic [AW-1:0]   core_addr;
    logic [WORD-1:0] core_inst;
    logic            core_stall, core_rst_n;
    logic [AW-1:0]   mem_A;
    logic            mem_W;
    logic [WORD-1:0] mem_D, mem_q;
    logic [AW:0]     load_count;
    logic            done, err;
    logic [WORD-1:0] checksum;

    imem_boot_ctrl #(.WORD(WORD), .AW(AW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_if      (lif.slave),
        .core_addr_i  (core_addr),
        .core_inst_o  (core_inst),
        .core_stall_o (core_stall),
        .core_rst_n_o (core_rst_n),
        .mem_A_o      (mem_A),
        .mem_W_o      (mem_W),
        .mem_D_o      (mem_D),
        .mem_Q_i      (mem_q),
        .load_count_o (load_count),
        .done_o       (done),
        .err_o        (err),
        .checksum_o   (checksum)
    );

    // single-port memory with 1-cycle read latency
    logic [WORD-1:0] mem_model [2**AW];
    always @(posedge clk) begin
        if (mem_W) mem_model[mem_A] <= mem_D;
        mem_q <= mem_model[mem_A];
    end

    // reference: program image and expected observable events
    logic [WORD-1:0] ref_mem [DEPTH];
    logic [63:0]     wr_q [$];
    logic [WORD-1:0] fq [$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WORD-1:0] exp_sum(input logic [WORD-1:0] s);
`ifdef IMEM_CHECKSUM_EN
        return s;
`else
        return '0;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor: every memory write and every running-core fetch is checked against the queues
    always @(negedge clk) begin
        if (reset === 1'b1 && mem_W === 1'b1) begin
            if (wr_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %0d data 0x%0h, none expected", mem_A, mem_D);
            end else begin
                logic [63:0] e;
                e = wr_q.pop_front();
                chk("wr_addr", 64'(mem_A), 64'(e[63:32]));
                chk("wr_data", 64'(mem_D), 64'(e[31:0]));
            end
        end
        if (reset === 1'b1 && core_stall === 1'b0) begin
            if (fq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_fetch: inst 0x%0h, none expected", core_inst);
            end else begin
                logic [WORD-1:0] f;
                f = fq.pop_front();
                chk("fetch_inst", 64'(core_inst), 64'(f));
            end
        end
    end

    // start a load (word offered with the start must be dropped), then stream the words
    task automatic load_prog(input logic [WORD-1:0] words[$], input bit with_last, input bit toggle);
        int n;
        int acc;
        logic [WORD-1:0] sum;
        n   = words.size();
        acc = 0;
        sum = '0;
        lif.load_start = 1'b1;
        lif.load_valid = 1'b1;
        lif.load_data  = $urandom;
        lif.load_last  = 1'b1;
        step();
        lif.load_start = 1'b0;
        chk("start_count", 64'(load_count), 64'd0);
        chk("start_err",   64'(err),        64'd0);
        chk("start_done",  64'(done),       64'd0);
        chk("start_rstn",  64'(core_rst_n), 64'd0);
        chk("start_stall", 64'(core_stall), 64'd1);
        chk("start_ready", 64'(lif.load_ready), 64'd1);
        chk("start_csum",  64'(checksum),   64'd0);
        while (acc < n) begin
            if (toggle && $urandom_range(0, 1) == 0) begin
                lif.load_valid = 1'b0;
                lif.load_last  = 1'b0;
                lif.load_data  = $urandom;
            end else begin
                lif.load_valid = 1'b1;
                lif.load_data  = words[acc];
                lif.load_last  = with_last && (acc == n - 1);
                wr_q.push_back({32'(acc), words[acc]});
                ref_mem[acc] = words[acc];
                sum = sum + words[acc];
                acc++;
            end
            step();
        end
        lif.load_valid = 1'b0;
        lif.load_last  = 1'b0;
        chk("load_count", 64'(load_count), 64'(n));
        chk("load_csum",  64'(checksum),   64'(exp_sum(sum)));
        if (with_last) begin
            chk("flush_stall", 64'(core_stall), 64'd1);
            chk("flush_rstn",  64'(core_rst_n), 64'd0);
            chk("flush_done",  64'(done),       64'd0);
            chk("flush_err",   64'(err),        64'd0);
        end else if (n == DEPTH) begin
            chk("ovf_err",   64'(err),            64'd1);
            chk("ovf_ready", 64'(lif.load_ready), 64'd0);
            chk("ovf_rstn",  64'(core_rst_n),     64'd0);
            chk("ovf_stall", 64'(core_stall),     64'd1);
        end else begin
            chk("partial_ready", 64'(lif.load_ready), 64'd1);
            chk("partial_err",   64'(err),            64'd0);
        end
    endtask

    // called in the FLUSH cycle; each address presented yields its word one cycle later
    task automatic run_phase(input int n, input int cycles);
        int a;
        a = $urandom_range(0, n - 1);
        core_addr = a[AW-1:0];
        for (int i = 0; i < cycles; i++) begin
            fq.push_back(ref_mem[a]);
            step();
            if (i == 0) begin
                chk("run_stall", 64'(core_stall), 64'd0);
                chk("run_rstn",  64'(core_rst_n), 64'd1);
                chk("run_done",  64'(done),       64'd1);
            end
            a = $urandom_range(0, n - 1);
            core_addr = a[AW-1:0];
        end
    endtask

    initial begin
        logic [WORD-1:0] q[$];
        int n;
        lif.load_start = 1'b0;
        lif.load_valid = 1'b0;
        lif.load_data  = '0;
        lif.load_last  = 1'b0;
        core_addr      = '0;

        reset = 1'b0;
        repeat (2) step();
        chk("rst_stall", 64'(core_stall),     64'd1);
        chk("rst_rstn",  64'(core_rst_n),     64'd0);
        chk("rst_ready", 64'(lif.load_ready), 64'd0);
        chk("rst_W",     64'(mem_W),          64'd0);
        chk("rst_count", 64'(load_count),     64'd0);
        chk("rst_done",  64'(done),           64'd0);
        chk("rst_err",   64'(err),            64'd0);
        chk("rst_csum",  64'(checksum),       64'd0);
        reset = 1'b1;
        step();

        q = '{32'h11, 32'h22, 32'h33, 32'h44};
        load_prog(q, 1'b1, 1'b0);
        run_phase(4, 6);

        repeat (5) begin
            n = $urandom_range(1, DEPTH);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back($urandom);
            load_prog(q, 1'b1, 1'b1);
            run_phase(n, $urandom_range(2, 6));
        end

        q.delete();
        for (int i = 0; i < DEPTH; i++) q.push_back($urandom);
        load_prog(q, 1'b0, 1'b1);
        lif.load_valid = 1'b1;
        lif.load_data  = $urandom;
        repeat (2) step();
        lif.load_valid = 1'b0;
        chk("idle_err_held",  64'(err),        64'd1);
        chk("idle_rstn_held", 64'(core_rst_n), 64'd0);

        q = '{32'hA5A5_0001, 32'h5A5A_0002};
        load_prog(q, 1'b0, 1'b0);

        q = '{32'hFFFF_FFFF, 32'h0000_0002};
        load_prog(q, 1'b1, 1'b0);
        chk("csum_wrap", 64'(checksum), 64'(exp_sum(32'h1)));
        run_phase(2, 3);

        lif.load_start = 1'b1;
        step();
        lif.load_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            lif.load_valid = 1'b1;
            lif.load_data  = $urandom;
            wr_q.push_back({32'(i), lif.load_data});
            ref_mem[i] = lif.load_data;
            step();
        end
        lif.load_valid = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("midrst_ready", 64'(lif.load_ready), 64'd0);
        chk("midrst_count", 64'(load_count),     64'd0);
        chk("midrst_stall", 64'(core_stall),     64'd1);

        repeat (2) step();
        chk("wr_q_drained", 64'(wr_q.size()), 64'd0);
        chk("fq_drained",   64'(fq.size()),   64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
